div_seq_32: RTL and testbench

Multi-cycle 32-bit integer divide sequencer for the MIPS32 divide path. It accepts one DIV/DIVU request and runs 32 restoring shift/compare/subtract iterations on operand magnitudes. It applies MIPS sign rules to the results and returns quotient and remainder for the HI/LO write-back. It owns the divide datapath exclusively: one operation in flight, no queueing.

---
 rtl/div_seq_32_if.sv | 25 ++
 rtl/div_seq_32.sv | 170 +++++++++++++++++
 tb/tb_div_seq_32.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_32_if.sv
// Request/response bundle for the sequential 32-bit divider.
// master = requesting pipeline stage, slave = divide sequencer.
interface div_seq_32_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_seq_32.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: magnitude divide over 32
// iterations, then sign fix-up of quotient (LO) and remainder (HI).
module div_seq_32 #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  div_seq_32_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    ITER,
    FIX
  } state_t;

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   dividend_q,  dividend_d;
  logic [WIDTH-1:0]   divisor_q,   divisor_d;
  logic               signed_q,    signed_d;
  logic [WIDTH-1:0]   dmag_q,      dmag_d;
  logic [WIDTH-1:0]   q_q,         q_d;
  logic [WIDTH-1:0]   r_q,         r_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               q_neg_q,     q_neg_d;
  logic               r_neg_q,     r_neg_d;
  logic               zero_q,      zero_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [WIDTH-1:0]   quotient_q,  quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q,       dbz_d;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH:0]     trial;

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    signed_d    = signed_q;
    dmag_d      = dmag_q;
    q_d         = q_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    a_neg       = 1'b0;
    b_neg       = 1'b0;
    trial       = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dividend_d = bus.dividend;
          divisor_d  = bus.divisor;
          signed_d   = bus.signed_op;
          busy_d     = 1'b1;
          state_d    = INIT;
        end
      end

      INIT: begin
        // |0x80000000| wraps to itself and is then treated as unsigned 2^31
        a_neg   = signed_q & dividend_q[WIDTH-1];
        b_neg   = signed_q & divisor_q[WIDTH-1];
        q_d     = a_neg ? -dividend_q : dividend_q;
        dmag_d  = b_neg ? -divisor_q : divisor_q;
        q_neg_d = a_neg ^ b_neg;
        r_neg_d = a_neg;
        r_d     = '0;
        cnt_d   = '0;
        zero_d  = (divisor_q == '0);
        state_d = (divisor_q == '0) ? FIX : ITER;
      end

      ITER: begin
        // Partial remainder stays below the divisor, so its 33rd bit is
        // always zero after a step and only 32 bits are kept.
        trial = {r_q, q_q[WIDTH-1]};
        if (trial >= {1'b0, dmag_q}) begin
          r_d = WIDTH'(trial - {1'b0, dmag_q});
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = dividend_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = q_neg_q ? -q_q : q_q;
          remainder_d = r_neg_q ? -r_q : r_q;
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      signed_q    <= 1'b0;
      dmag_q      <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      signed_q    <= signed_d;
      dmag_q      <= dmag_d;
      q_q         <= q_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

  busy_done_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(busy_q && done_q));

endmodule

// File: tb/tb_div_seq_32.sv
// Directed bench for div_seq_32: sign rules, corners, divide by zero,
// handshake timing and asynchronous reset abort.
module tb_div_seq_32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_seq_32_if #(.WIDTH(32)) bus ();

  div_seq_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Called #1 after a rising edge with the divider idle. Returns the number of
  // edges from the accepting edge to the edge after which done is seen
  // (-1 on timeout), the number of busy samples and busy&done overlaps.
  task automatic run_div(input logic sop, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n, output int overlap);
    bus.signed_op = sop;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.dividend  = 32'hDEAD_BEEF;
    bus.divisor   = 32'h0000_0003;
    lat     = -1;
    busy_n  = (bus.busy === 1'b1) ? 1 : 0;
    overlap = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.busy === 1'b1) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    #12;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== 65'd0) begin
      errors++;
      $display("FAIL reset_data q=%h r=%h z=%b expected 0 0 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_unsigned();
    int lat, bn, ov;
    run_div(1'b0, 32'd100, 32'd7, lat, bn, ov);
    checks++;
    if (lat !== 34) begin
      errors++;
      $display("FAIL divu_latency got %0d expected 34", lat);
    end
    checks++;
    if (bn !== 34) begin
      errors++;
      $display("FAIL divu_busy_cycles got %0d expected 34", bn);
    end
    checks++;
    if (ov !== 0) begin
      errors++;
      $display("FAIL busy_done_overlap got %0d expected 0", ov);
    end
    checks++;
    if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL divu_100_7 q=%h r=%h z=%b expected 0000000e 00000002 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
      errors++;
      $display("FAIL done_pulse_hold done=%b q=%h r=%h expected 0 0000000e 00000002",
               bus.done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_signed();
    logic [31:0] a  [3] = '{32'hFFFF_FF9C, 32'd100,      32'hFFFF_FF9C};
    logic [31:0] b  [3] = '{32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] eq [3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14};
    logic [31:0] er [3] = '{32'hFFFF_FFFE, 32'd2,         32'hFFFF_FFFE};
    int lat, bn, ov;
    for (int i = 0; i < 3; i++) begin
      run_div(1'b1, a[i], b[i], lat, bn, ov);
      checks++;
      if (lat !== 34 || bus.quotient !== eq[i] || bus.remainder !== er[i]
          || bus.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL div_sign_%0d lat=%0d q=%h r=%h z=%b expected 34 %h %h 0",
                 i, lat, bus.quotient, bus.remainder, bus.div_by_zero, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_corners();
    logic        s  [3] = '{1'b1,         1'b0,         1'b0};
    logic [31:0] a  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] b  [3] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    logic [31:0] eq [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] er [3] = '{32'd0,         32'd0,         32'd5};
    int lat, bn, ov;
    for (int i = 0; i < 3; i++) begin
      run_div(s[i], a[i], b[i], lat, bn, ov);
      checks++;
      if (lat !== 34 || bus.quotient !== eq[i] || bus.remainder !== er[i]
          || bus.div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL corner_%0d lat=%0d q=%h r=%h z=%b expected 34 %h %h 0",
                 i, lat, bus.quotient, bus.remainder, bus.div_by_zero, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bn, ov;
    bit seen;
    run_div(1'b1, 32'd1234, 32'd0, lat, bn, ov);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL dbz_latency got %0d expected 2", lat);
    end
    checks++;
    if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd1234 || bus.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result q=%h r=%h z=%b expected ffffffff 000004d2 1",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.div_by_zero !== 1'b1 || bus.quotient !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL dbz_held z=%b q=%h expected 1 ffffffff", bus.div_by_zero, bus.quotient);
    end
    seen = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || bus.div_by_zero !== 1'b0 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
      errors++;
      $display("FAIL dbz_cleared done=%b z=%b q=%h r=%h expected 1 0 0000000e 00000002",
               seen, bus.div_by_zero, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    int extra = 0;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      bus.start = (k == 12);
      if (k == 12) begin
        bus.signed_op = 1'b1;
        bus.dividend  = 32'd50;
        bus.divisor   = 32'd5;
      end
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (lat !== 34 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
      errors++;
      $display("FAIL ignore_start lat=%0d q=%h r=%h expected 34 0000000e 00000002",
               lat, bus.quotient, bus.remainder);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_start_queued activity=%0d expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn, ov;
    int lat2 = -1;
    run_div(1'b0, 32'd100, 32'd7, lat, bn, ov);
    checks++;
    if (lat !== 34 || bus.quotient !== 32'd14) begin
      errors++;
      $display("FAIL b2b_first lat=%0d q=%h expected 34 0000000e", lat, bus.quotient);
    end
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept busy=%b done=%b expected 1 0", bus.busy, bus.done);
    end
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat2 = k;
        break;
      end
    end
    checks++;
    if (lat2 !== 34 || bus.quotient !== 32'd333 || bus.remainder !== 32'd1) begin
      errors++;
      $display("FAIL b2b_second lat=%0d q=%h r=%h expected 34 0000014d 00000001",
               lat2, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn, ov;
    int extra = 0;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre busy=%b expected 1", bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 32'd0
        || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async busy=%b done=%b q=%h r=%h z=%b expected all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL midrst_no_done activity=%0d expected 0", extra);
    end
    run_div(1'b0, 32'd100, 32'd7, lat, bn, ov);
    checks++;
    if (lat !== 34 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
      errors++;
      $display("FAIL midrst_recover lat=%0d q=%h r=%h expected 34 0000000e 00000002",
               lat, bus.quotient, bus.remainder);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_corners();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
